// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the small CPU: instruction/PC widths, the bit
// positions of each instruction field, the HALT opcode, the fetch sequencer
// state encoding and a helper that spots a HALT instruction.
// Instruction layout: {opcode[16:12], DA[11:9], RA[8:6], RB[5:3], IM[2:0]}
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 17;

    localparam int OP_MSB = 16;
    localparam int OP_LSB = 12;
    localparam int DA_MSB = 11;
    localparam int DA_LSB = 9;
    localparam int RA_MSB = 8;
    localparam int RA_LSB = 6;
    localparam int RB_MSB = 5;
    localparam int RB_LSB = 3;
    localparam int IM_MSB = 2;
    localparam int IM_LSB = 0;

    localparam logic [4:0]      HALT_OP  = 5'b11111;
    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

    // True when the opcode field of an instruction word equals the halt code.
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr,
                                     input logic [4:0]         halt_op);
        return instr[OP_MSB:OP_LSB] == halt_op;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
// Purely combinational split of an instruction register into its fields.
// Kept separate so the hazard unit can reuse the same field extraction.
// Ports:
//   ir      in   INSTR_W  instruction register contents
//   opcode  out  5        ir[16:12]
//   da      out  3        ir[11:9]  destination register
//   ra      out  3        ir[8:6]   source A
//   rb      out  3        ir[5:3]   source B
//   im      out  3        ir[2:0]   immediate
// ----------------------------------------------------------------------------
module instr_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [4:0]         opcode,
    output logic [2:0]         da,
    output logic [2:0]         ra,
    output logic [2:0]         rb,
    output logic [2:0]         im
);

    assign opcode = ir[OP_MSB:OP_LSB];
    assign da     = ir[DA_MSB:DA_LSB];
    assign ra     = ir[RA_MSB:RA_LSB];
    assign rb     = ir[RB_MSB:RB_LSB];
    assign im     = ir[IM_MSB:IM_LSB];

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter for the 256 x 17-bit program memory, captures each
// fetched word into an instruction register and presents the decoded fields
// to the execute stage over a valid/ready handshake. Handles taken branches,
// stops on a HALT opcode and restarts from RESET_PC on a start pulse.
// Ports:
//   clk           in   1        rising-edge clock
//   rst_n         in   1        asynchronous active-low reset
//   start         in   1        begin / restart execution at RESET_PC
//   prg_counter   out  PC_W     registered PC, address to program memory
//   instructions  in   INSTR_W  combinational read data from program memory
//   issue_valid   out  1        decoded instruction presented
//   issue_ready   in   1        execute stage accepts this cycle
//   opcode        out  5        decoded opcode
//   da/ra/rb/im   out  3 each   decoded register / immediate fields
//   issue_pc      out  PC_W     address the presented instruction came from
//   br_taken      in   1        redirect PC (used only on a handshake)
//   br_target     in   PC_W     redirect address
//   busy          out  1        fetching or issuing
//   halted        out  1        HALT fetched, sequencer stopped
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [4:0]      HALT_OP  = cpu_pkg::HALT_OP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    prg_counter,
    input  logic [INSTR_W-1:0] instructions,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [4:0]         opcode,
    output logic [2:0]         da,
    output logic [2:0]         ra,
    output logic [2:0]         rb,
    output logic [2:0]         im,
    output logic [PC_W-1:0]    issue_pc,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               busy,
    output logic               halted
);

    import cpu_pkg::*;

    seq_state_t         state;
    seq_state_t         state_next;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] ir_next;
    logic [PC_W-1:0]    issue_pc_q;
    logic [PC_W-1:0]    issue_pc_next;

    // State, PC, IR and the issue address all live here. Reset puts the
    // sequencer in IDLE with a cleared IR so every decoded field reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            issue_pc_q <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ir         <= ir_next;
            issue_pc_q <= issue_pc_next;
        end
    end

    // Next-state and handshake logic. start wins over everything else in any
    // state: it forces the PC back to RESET_PC and the next cycle is a fetch.
    // issue_valid is also masked by start so a restart never looks like an
    // accepted instruction, even when issue_ready is high in the same cycle.
    // PC+1 wraps naturally at the PC width.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        ir_next       = ir;
        issue_pc_next = issue_pc_q;
        issue_valid   = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    state_next = FETCH;
                end
            end

            FETCH: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    state_next = FETCH;
                end else begin
                    ir_next       = instructions;
                    issue_pc_next = pc;
                    if (is_halt(instructions, HALT_OP)) begin
                        state_next = HALTED;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    state_next = FETCH;
                end else begin
                    issue_valid = 1'b1;
                    if (issue_ready) begin
                        pc_next    = br_taken ? br_target : pc + PC_W'(1);
                        state_next = FETCH;
                    end
                end
            end

            HALTED: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    instr_decode u_decode (
        .ir     (ir),
        .opcode (opcode),
        .da     (da),
        .ra     (ra),
        .rb     (rb),
        .im     (im)
    );

    assign prg_counter = pc;
    assign issue_pc    = issue_pc_q;
    assign busy        = (state == FETCH) || (state == ISSUE);
    assign halted      = (state == HALTED);

endmodule
